// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: a 128-bit state is substituted BYTES_PER_CYCLE bytes
// per clock through a bank of forward S-boxes, then held until downstream takes it.

module sub_bytes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_byte = SBOX_TBL[in_byte];

endmodule

module sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready depends only on the FSM state, never on valid.

   localparam int N  = 16 / BYTES_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   data_sub;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;

   logic [7:0]     lane_in  [BYTES_PER_CYCLE];
   logic [7:0]     lane_out [BYTES_PER_CYCLE];

   // Lane l works on byte cnt*BYTES_PER_CYCLE + l; byte 0 sits in the top bits.
   always_comb begin
      for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
         lane_in[l] = 8'h00;
         for (int b = 0; b < 16; b++) begin
            if (b == int'(cnt_q) * BYTES_PER_CYCLE + l) begin
               lane_in[l] = data_q[127-8*b -: 8];
            end
         end
      end
   end

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      sub_bytes_sbox u_sbox (
         .in_byte  (lane_in[g]),
         .out_byte (lane_out[g])
      );
   end

   always_comb begin
      data_sub = data_q;
      for (int b = 0; b < 16; b++) begin
         for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            if (b == int'(cnt_q) * BYTES_PER_CYCLE + l) begin
               data_sub[127-8*b -: 8] = lane_out[l];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d    = BUSY;
               data_d     = in_data;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         BUSY: begin
            data_d = data_sub;
            if (cnt_q == CW'(N - 1)) begin
               state_d     = DONE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = data_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule
